vga_frame_checker: RTL and testbench

// - Receive-side monitor for the VGA port driven by top (hsync, vsync, blank_b, r, g, b).
// - Recovers line and frame timing, checks it against 640x480@60 parameters and computes a per-frame pixel checksum.
// - Used in top-level benches and as an on-board self-test.
// - Runs on the system clock; each vgaclk pixel is qualified by pix_en.

---
 rtl/vga_chk_pkg.sv | 26 ++
 rtl/vga_sync_edge.sv | 41 ++++
 rtl/vga_frame_checker.sv | 214 +++++++++++++++++++++
 tb/tb_vga_frame_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_chk_pkg.sv
// Shared types and constants for the VGA frame checker.
//   state_t      : checker FSM states
//   ERR_*        : bit positions in the err vector
//   cs_step()    : one checksum update for one active pixel
package vga_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam int ERR_HTOT = 0;
    localparam int ERR_HACT = 1;
    localparam int ERR_VTOT = 2;
    localparam int ERR_VACT = 3;
    localparam int ERR_SYNC = 4;
    localparam int ERR_W    = 5;

    // Rotate-left by one, then fold in the 24-bit pixel.
    function automatic logic [31:0] cs_step(input logic [31:0] cs, input logic [23:0] pix);
        return {cs[30:0], cs[31]} ^ {8'h00, pix};
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Falling-edge detector and saturating low-width counter for one sync line.
//   clk, reset  : system clock, synchronous active-high reset
//   pix_en      : sample strobe; history and counter only move on strobes
//   sync_in     : active-low sync input
//   clear       : hold the width counter at zero
//   fall        : combinational, 1 on a strobe where sync_in went 1 -> 0
//   low_width   : samples in the most recent low pulse (saturates at 255);
//                 on a fall cycle it still holds the previous pulse's width
module vga_sync_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       sync_in,
    input  logic       clear,
    output logic       fall,
    output logic [7:0] low_width
);

    // Syncs idle high, so history starts at 1 and a line held low from
    // reset produces an edge on its first sample.
    logic prev;

    assign fall = pix_en & prev & ~sync_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= 1'b1;
            low_width <= '0;
        end else begin
            if (pix_en)
                prev <= sync_in;
            if (clear)
                low_width <= '0;
            else if (fall)
                low_width <= 8'd1;
            else if (pix_en && !sync_in && low_width != 8'hFF)
                low_width <= low_width + 8'd1;
        end
    end

endmodule

// File: rtl/vga_frame_checker.sv
// Receive-side VGA timing monitor: recovers line/frame timing from
// hsync/vsync/blank_b, checks it against the configured geometry and
// computes a per-frame checksum of the active pixels.
//   clk, reset   : system clock, synchronous active-high reset
//   enable       : 1 = measure, 0 = abort to IDLE (outputs held)
//   pix_en       : one-clk strobe qualifying the VGA inputs
//   hsync, vsync : active-low syncs
//   blank_b      : 1 = active pixel
//   r, g, b      : pixel colour
//   busy         : 1 in SEEK or MEASURE
//   frame_done   : one-clk pulse when a frame report is published
//   frame_ok     : err == 0 for the last report
//   err          : [0]H_TOTAL [1]H_ACTIVE [2]V_TOTAL [3]V_ACTIVE [4]SYNC_WIDTH
//   checksum     : checksum of the last reported frame
//   frame_cnt    : reports since reset, wraps
module vga_frame_checker
    import vga_chk_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_TOTAL   = 800,
    parameter int HSYNC_LEN = 96,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525,
    parameter int VSYNC_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pix_en,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank_b,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [ERR_W-1:0] err,
    output logic [31:0]      checksum,
    output logic [15:0]      frame_cnt
);

    localparam logic [11:0] H_TOT_C  = 12'(H_TOTAL);
    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [7:0]  HS_LEN_C = 8'(HSYNC_LEN);
    localparam logic [10:0] V_TOT_C  = 11'(V_TOTAL);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [3:0]  VS_LEN_C = 4'(VSYNC_LEN);

    state_t state, state_nxt;

    logic        hs_fall, vs_fall;
    logic [7:0]  hs_width;
    logic [7:0]  vs_width_unused;
    logic [23:0] pix;

    logic [11:0]      h_cnt, act_cnt;
    logic [10:0]      lines, act_lines, act_lines_nxt;
    logic [3:0]       vs_low;
    logic             line_valid;   // current line began with an hsync edge inside this frame
    logic [ERR_W-1:0] err_acc, err_line, err_frame;
    logic [31:0]      cs;

    logic measuring, close, start, line_chk, act_inc;

    assign pix  = {r, g, b};
    assign busy = (state == SEEK) || (state == MEASURE);

    // ---------------------------------------------------------------
    // Sync edge detection
    // ---------------------------------------------------------------
    vga_sync_edge u_hs (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .sync_in   (hsync),
        .clear     (state == IDLE),
        .fall      (hs_fall),
        .low_width (hs_width)
    );

    // vsync width is measured in lines below, not in samples.
    vga_sync_edge u_vs (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .sync_in   (vsync),
        .clear     (state == IDLE),
        .fall      (vs_fall),
        .low_width (vs_width_unused)
    );

    // REPORT lasts one clk but a strobe may land in it; it keeps counting
    // the frame that started on the closing edge so frames are gap-free.
    assign measuring = enable && (state == MEASURE || state == REPORT);
    assign close     = enable && (state == MEASURE) && vs_fall;
    // The closing edge of one frame is also the opening edge of the next.
    assign start     = enable && vs_fall && (state == SEEK || state == MEASURE);
    assign line_chk  = measuring && hs_fall && line_valid;
    assign act_inc   = line_chk && (act_cnt != '0);

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = SEEK;
            SEEK:    if (vs_fall) state_nxt = MEASURE;
            MEASURE: if (vs_fall) state_nxt = REPORT;
            REPORT:               state_nxt = MEASURE;
            default:              state_nxt = IDLE;
        endcase
        if (!enable)
            state_nxt = IDLE;
    end

    // ---------------------------------------------------------------
    // Line and frame checks
    // ---------------------------------------------------------------
    always_comb begin
        err_line      = '0;
        act_lines_nxt = act_lines;
        if (line_chk) begin
            err_line[ERR_HTOT] = (h_cnt != H_TOT_C);
            err_line[ERR_HACT] = (act_cnt != '0) && (act_cnt != H_ACT_C);
            err_line[ERR_SYNC] = (hs_width != HS_LEN_C);
        end
        if (act_inc && act_lines != '1)
            act_lines_nxt = act_lines + 11'd1;

        // The line ending on the closing edge belongs to the closing frame.
        err_frame           = err_acc | err_line;
        err_frame[ERR_VTOT] = err_frame[ERR_VTOT] | (lines != V_TOT_C);
        err_frame[ERR_VACT] = err_frame[ERR_VACT] | (act_lines_nxt != V_ACT_C);
        err_frame[ERR_SYNC] = err_frame[ERR_SYNC] | (vs_low != VS_LEN_C);
    end

    // ---------------------------------------------------------------
    // Measurement counters (all saturating)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt      <= '0;
            act_cnt    <= '0;
            lines      <= '0;
            act_lines  <= '0;
            vs_low     <= '0;
            line_valid <= 1'b0;
            err_acc    <= '0;
            cs         <= '0;
        end else if (start) begin
            // The opening sample is the first sample of the new frame; a
            // coincident hsync edge makes it line 0.
            h_cnt      <= 12'd1;
            act_cnt    <= {11'd0, blank_b};
            lines      <= {10'd0, hs_fall};
            vs_low     <= {3'd0, hs_fall};
            act_lines  <= '0;
            line_valid <= hs_fall;
            err_acc    <= '0;
            cs         <= blank_b ? cs_step(32'd0, pix) : 32'd0;
        end else if (measuring && pix_en) begin
            if (hs_fall) begin
                h_cnt      <= 12'd1;
                act_cnt    <= {11'd0, blank_b};
                line_valid <= 1'b1;
                act_lines  <= act_lines_nxt;
                err_acc    <= err_acc | err_line;
                if (lines != '1)
                    lines <= lines + 11'd1;
                if (!vsync && vs_low != '1)
                    vs_low <= vs_low + 4'd1;
            end else begin
                if (h_cnt != '1)
                    h_cnt <= h_cnt + 12'd1;
                if (blank_b && act_cnt != '1)
                    act_cnt <= act_cnt + 12'd1;
            end
            if (blank_b)
                cs <= cs_step(cs, pix);
        end
    end

    // ---------------------------------------------------------------
    // Report registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err        <= '0;
            checksum   <= '0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= close;
            if (close) begin
                err       <= err_frame;
                frame_ok  <= (err_frame == '0);
                checksum  <= cs;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker on a reduced geometry. Frames are described
// as per-line tables (total samples, hsync width, active samples) plus
// frame-level line count and vsync width; the expected report for each
// frame is derived from those tables and the pixels sent.
module tb_vga_frame_checker;

    localparam int HA  = 12;   // active samples per line
    localparam int HT  = 24;   // samples per line
    localparam int HSL = 4;    // hsync low samples
    localparam int HBP = 6;    // first active sample within a line
    localparam int VA  = 8;    // active lines
    localparam int VT  = 12;   // lines per frame
    localparam int VSL = 2;    // vsync low lines
    localparam int VBP = 3;    // first active line

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank_b = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        busy, frame_done, frame_ok;
    logic [4:0]  err;
    logic [31:0] checksum;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    vga_frame_checker #(
        .H_ACTIVE (HA), .H_TOTAL (HT), .HSYNC_LEN (HSL),
        .V_ACTIVE (VA), .V_TOTAL (VT), .VSYNC_LEN (VSL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_b    (blank_b),
        .r          (r),
        .g          (g),
        .b          (b),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err        (err),
        .checksum   (checksum),
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        logic [4:0]  err;
        logic [31:0] cs;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        pend, last_exp, mon_e;
    bit          pend_valid = 0;
    logic [15:0] mdl_cnt = '0;
    int          n_chk = 0, n_fail = 0, n_done = 0, n_push = 0, n_before;

    int ln_htot[64], ln_hsw[64], ln_nact[64];
    int f_vtot, f_vsl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic setup_ideal();
        f_vtot = VT;
        f_vsl  = VSL;
        for (int y = 0; y < 64; y++) begin
            ln_htot[y] = HT;
            ln_hsw[y]  = HSL;
            ln_nact[y] = (y >= VBP && y < VBP + VA) ? HA : 0;
        end
    endtask

    // Drive one frame from the tables; stop_line >= 0 abandons it after
    // that line. The frame's report is expected on the next frame's start.
    task automatic drive_frame(input bit rnd_pix, input int gap_min, input int gap_max,
                               input int stop_line);
        logic [31:0] cs;
        logic [4:0]  e;
        logic [23:0] px;
        logic        act;
        int          nal;
        cs = '0; e = '0; nal = 0;
        for (int y = 0; y < f_vtot; y++) begin
            if (ln_htot[y] != HT)                    e[0] = 1'b1;
            if (ln_nact[y] != 0 && ln_nact[y] != HA) e[1] = 1'b1;
            if (ln_hsw[y] != HSL)                    e[4] = 1'b1;
            if (ln_nact[y] != 0)                     nal++;
        end
        if (f_vtot != VT)  e[2] = 1'b1;
        if (nal != VA)     e[3] = 1'b1;
        if (f_vsl != VSL)  e[4] = 1'b1;

        for (int y = 0; y < f_vtot; y++) begin
            for (int x = 0; x < ln_htot[y]; x++) begin
                act = (x >= HBP) && (x < HBP + ln_nact[y]);
                px  = rnd_pix ? 24'($urandom) : {8'(x - HBP), 8'(y), 8'h00};
                if (act) cs = {cs[30:0], cs[31]} ^ {8'h00, px};
                @(negedge clk);
                if (y == 0 && x == 0 && pend_valid) begin
                    mdl_cnt  = mdl_cnt + 16'd1;
                    pend.cnt = mdl_cnt;
                    exp_q.push_back(pend);
                    n_push++;
                    pend_valid = 0;
                end
                hsync   = !(x < ln_hsw[y]);
                vsync   = !(y < f_vsl);
                blank_b = act;
                {r, g, b} = px;
                pix_en  = 1'b1;
                @(negedge clk);
                pix_en  = 1'b0;
                repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
            end
            if (y == stop_line) break;
        end
        if (stop_line < 0 && enable) begin
            pend.err   = e;
            pend.cs    = cs;
            pend.cnt   = '0;
            pend_valid = 1;
        end
    endtask

    // Report scoreboard
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            n_done++;
            chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("err", 32'(err), 32'(mon_e.err));
                chk("frame_ok", 32'(frame_ok), 32'(mon_e.err == 5'd0));
                chk("checksum", checksum, mon_e.cs);
                chk("frame_cnt", 32'(frame_cnt), 32'(mon_e.cnt));
                last_exp = mon_e;
            end
        end
    end

    initial begin
        last_exp = '{5'd0, 32'd0, 16'd0};
        setup_ideal();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ok", 32'(frame_ok), 0);
        chk("rst_cs", checksum, 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("seek_busy", 32'(busy), 1);

        // Nominal: three ideal frames, strobe every 4th clk
        for (int k = 0; k < 3; k++) begin
            setup_ideal();
            drive_frame(0, 2, 2, -1);
        end
        chk("nominal_reports", n_done, 2);
        chk("nominal_cnt", 32'(frame_cnt), 2);
        chk("nominal_ok", 32'(frame_ok), 1);

        // Directed timing faults, each followed by its closing frame
        setup_ideal(); ln_htot[5] = HT - 1;  drive_frame(1, 0, 3, -1);
        setup_ideal();                        drive_frame(1, 0, 3, -1);
        chk("short_line_err", 32'(err), 32'b00001);
        setup_ideal(); ln_nact[VBP] = 0;      drive_frame(1, 0, 3, -1);
        chk("recover_err", 32'(err), 0);
        setup_ideal(); f_vsl = 3;             drive_frame(1, 0, 3, -1);
        chk("missing_act_line_err", 32'(err), 32'b01000);
        setup_ideal(); ln_hsw[4] = HSL - 1;   drive_frame(1, 0, 3, -1);
        chk("vsync_3_lines_err", 32'(err), 32'b10000);
        setup_ideal();                        drive_frame(1, 0, 3, -1);
        chk("hsync_short_err", 32'(err), 32'b10000);

        // Random frames with random single faults
        for (int k = 0; k < 6; k++) begin
            setup_ideal();
            case ($urandom_range(5, 0))
                1: ln_htot[$urandom_range(VT - 1, 0)] = HT + 1;
                2: ln_nact[VBP + $urandom_range(VA - 1, 0)] = HA - 1 - int'($urandom_range(3, 0));
                3: f_vtot = ($urandom_range(1, 0) != 0) ? VT + 1 : VT - 1;
                4: f_vsl  = ($urandom_range(1, 0) != 0) ? 1 : 3;
                5: ln_hsw[$urandom_range(VT - 1, 0)] = HSL + 1;
                default: ;
            endcase
            drive_frame(1, 0, 3, -1);
        end

        // Counter wrap
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        mdl_cnt = 16'hFFFF;
        n_before = n_done;
        setup_ideal(); drive_frame(1, 0, 3, -1);
        chk("wrap_done", n_done, n_before + 1);
        chk("wrap_cnt", 32'(frame_cnt), 0);

        // Abort mid-frame
        setup_ideal(); drive_frame(1, 0, 3, 5);
        @(negedge clk);
        enable = 1'b0;
        pend_valid = 0;
        n_before = n_done;
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_err_held", 32'(err), 32'(last_exp.err));
        chk("abort_cs_held", checksum, last_exp.cs);
        chk("abort_cnt_held", 32'(frame_cnt), 32'(last_exp.cnt));
        setup_ideal(); drive_frame(1, 0, 1, -1);
        chk("abort_no_done", n_done, n_before);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        setup_ideal(); drive_frame(1, 0, 2, -1);
        chk("reenable_one_edge", n_done, n_before);
        setup_ideal(); drive_frame(1, 0, 2, -1);
        chk("reenable_two_edges", n_done, n_before + 1);

        // Reset mid-frame
        setup_ideal(); drive_frame(1, 0, 2, 4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_ok", 32'(frame_ok), 0);
        chk("mid_rst_cs", checksum, 0);
        chk("mid_rst_cnt", 32'(frame_cnt), 0);
        reset = 1'b0;
        mdl_cnt = '0;
        pend_valid = 0;
        repeat (2) @(negedge clk);
        setup_ideal(); drive_frame(1, 0, 2, -1);
        setup_ideal(); drive_frame(1, 0, 2, -1);
        chk("post_rst_cnt", 32'(frame_cnt), 1);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("report_count", n_done, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
